ntt_delay_line: RTL and testbench

//  Multi-lane programmable delay line (RAM + wrapping address counter) for NTT/INTT butterfly

---
 rtl/ntt_delay_line.sv | 228 ++++++++++++++++++++++
 tb/tb_ntt_delay_line.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_delay_line.sv
// ---------------------------------------------------------------------------
// ntt_delay_line
//
// Purpose
//   Multi-lane programmable delay line used to align butterfly operands
//   between the multiplier/butterfly pipeline stages of an NTT/INTT stage.
//   All LANES coefficient lanes share one address counter and one RAM word,
//   so the lanes always stay in lock-step.
//
//   The delay D is counted in enabled cycles (en=1). Stalled cycles freeze
//   the whole line. flush clears the fill/valid tracking synchronously.
//
// Implementation
//   D = 0  : combinational passthrough (out_valid = in_valid & en).
//   D = 1  : a single output register written on enabled edges.
//   D >= 2 : a RAM of D-1 {valid,data} words plus the output register.
//            Each enabled edge reads the word at addr into the output
//            register and then overwrites that word with the current input
//            (read-before-write), so a word makes one full lap of D-1
//            entries plus one register stage = D enabled cycles.
//
// Valid semantics
//   There is no backpressure. in_valid qualifies in_data on an enabled,
//   non-flush edge; out_valid qualifies out_data while it is high and
//   out_data carries no meaning while out_valid is low. A fill counter
//   keeps out_valid low until D enabled edges have been seen since
//   reset/flush, so stale RAM contents can never appear as valid data.
//
// Build option
//   NTT_DELAY_PROG_EN : when defined, the delay is runtime programmable
//   through delay_cfg (registered every cycle, clamped to MAX_DELAY, reset
//   value DELAY). A change of the registered delay flushes the line on the
//   same edge that loads it. The RAM is then sized MAX_DELAY-1.
//   When undefined, delay_cfg does not exist, D = DELAY and the RAM is
//   sized DELAY-1.
//
// Ports
//   clk        in   1              rising-edge clock
//   rst_n      in   1              asynchronous active-low reset
//   en         in   1              advance the line this cycle; 0 = stall
//   flush      in   1              synchronous clear of fill/valid state
//   delay_cfg  in   DW             runtime delay (NTT_DELAY_PROG_EN only)
//   in_valid   in   1              lane data valid
//   in_data    in   LANES x WIDTH  lane data
//   out_valid  out  1              delayed valid
//   out_data   out  LANES x WIDTH  delayed data
//   filled     out  1              D enabled edges seen since reset/flush
// ---------------------------------------------------------------------------
module ntt_delay_line #(
    parameter int WIDTH     = 12,
    parameter int LANES     = 2,
    parameter int MAX_DELAY = 64,
    parameter int DELAY     = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                en,
    input  logic                                flush,
`ifdef NTT_DELAY_PROG_EN
    input  logic [$clog2(MAX_DELAY+1)-1:0]      delay_cfg,
`endif
    input  logic                                in_valid,
    input  logic [LANES-1:0][WIDTH-1:0]         in_data,
    output logic                                out_valid,
    output logic [LANES-1:0][WIDTH-1:0]         out_data,
    output logic                                filled
);

    // Width of delay values and of the fill counter.
    localparam int DW = $clog2(MAX_DELAY + 1);
    // One RAM word holds the valid bit above all lane data.
    localparam int EW = LANES * WIDTH + 1;

`ifdef NTT_DELAY_PROG_EN
    localparam bit HAS_RAM   = 1'b1;
    localparam int RAM_DEPTH = MAX_DELAY - 1;
`else
    localparam bit HAS_RAM   = (DELAY >= 2);
    localparam int RAM_DEPTH = (DELAY >= 2) ? DELAY - 1 : 1;
`endif
    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    // Elaboration-time parameter checks.
    if (MAX_DELAY < 2) begin : g_bad_max
        $error("ntt_delay_line: MAX_DELAY must be at least 2");
    end
    if (DELAY < 0 || DELAY > MAX_DELAY) begin : g_bad_delay
        $error("ntt_delay_line: DELAY must lie in 0..MAX_DELAY");
    end

    // ------------------------------------------------------------------
    // Active delay and effective flush
    // ------------------------------------------------------------------
    logic [DW-1:0] d_w;    // active delay D
    logic          clr;    // flush request for this edge (explicit or reconfig)

`ifdef NTT_DELAY_PROG_EN
    logic [DW-1:0] d_q;
    logic [DW-1:0] d_d;
    logic          cfg_chg;

    // Out-of-range requests saturate at the largest supported delay.
    assign d_d     = (delay_cfg > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : delay_cfg;
    // The edge that loads a new delay also restarts the line, so no sample
    // written under the old delay can emerge under the new one.
    assign cfg_chg = (d_d != d_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= DW'(DELAY);
        end else begin
            d_q <= d_d;
        end
    end

    assign d_w = d_q;
    assign clr = flush | cfg_chg;
`else
    assign d_w = DW'(DELAY);
    assign clr = flush;
`endif

    // ------------------------------------------------------------------
    // Storage: RAM of {valid,data} words with a wrapping address counter
    // ------------------------------------------------------------------
    logic [EW-1:0] rd_word;   // word at the current address, before write

    if (HAS_RAM) begin : g_ram
        logic [EW-1:0] ram_q [RAM_DEPTH];
        logic [AW-1:0] addr_q;
        logic [AW-1:0] addr_d;
        logic          ram_we;

        always_comb begin
            addr_d = addr_q;
            ram_we = 1'b0;
            if (clr) begin
                addr_d = '0;
            end else if (en && (d_w >= DW'(2))) begin
                ram_we = 1'b1;
                // Only D-1 words are in use, so wrap after address D-2.
                if (DW'(addr_q) == (d_w - DW'(2))) begin
                    addr_d = '0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                addr_q <= '0;
            end else begin
                addr_q <= addr_d;
            end
        end

        // RAM contents are deliberately not reset; the fill counter hides
        // whatever they hold until they have been rewritten.
        always_ff @(posedge clk) begin
            if (ram_we) begin
                ram_q[addr_q] <= {in_valid, in_data};
            end
        end

        assign rd_word = ram_q[addr_q];
    end else begin : g_no_ram
        assign rd_word = '0;
    end

    // ------------------------------------------------------------------
    // Output register and fill tracking
    // ------------------------------------------------------------------
    logic [DW-1:0]               fill_q;
    logic [DW-1:0]               fill_d;
    logic [LANES-1:0][WIDTH-1:0] out_data_q;
    logic [LANES-1:0][WIDTH-1:0] out_data_d;
    logic                        out_vld_q;
    logic                        out_vld_d;

    always_comb begin
        fill_d     = fill_q;
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;
        if (clr) begin
            // out_data is left alone: it is meaningless while invalid.
            fill_d    = '0;
            out_vld_d = 1'b0;
        end else if (en) begin
            if (fill_q < d_w) begin
                fill_d = fill_q + DW'(1);
            end
            if (d_w == DW'(1)) begin
                out_data_d = in_data;
                out_vld_d  = in_valid;
            end else if (d_w >= DW'(2)) begin
                out_data_d = rd_word[EW-2:0];
                out_vld_d  = rd_word[EW-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q     <= '0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            fill_q     <= fill_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
        end
    end

    // With D=0 the fill counter stays at 0, so filled reads 1 permanently.
    assign filled = (fill_q == d_w);

    always_comb begin
        if (d_w == '0) begin
            out_data  = in_data;
            out_valid = in_valid & en;
        end else begin
            out_data  = out_data_q;
            out_valid = out_vld_q & filled;
        end
    end

endmodule

// File: tb/tb_ntt_delay_line.sv
module tb_ntt_delay_line;

    localparam int WIDTH     = 12;
    localparam int LANES     = 2;
    localparam int MAX_DELAY = 64;
    localparam int DW        = $clog2(MAX_DELAY + 1);
    localparam int W         = LANES * WIDTH + 1;
    localparam int NDUT      = 5;
    localparam int IDX_D4    = 3;
    localparam int IDX_D5    = 4;

    typedef logic [LANES-1:0][WIDTH-1:0] lanes_t;

    // Delay of each instance, indexed by instance number.
    function automatic int dly_of(input int g);
        case (g)
            0:       return 0;
            1:       return 1;
            2:       return 2;
            3:       return 4;
            default: return 5;
        endcase
    endfunction

    function automatic lanes_t mk_lanes(input logic [WIDTH-1:0] l0, input logic [WIDTH-1:0] l1);
        lanes_t r;
        r[0] = l0;
        r[1] = l1;
        return r;
    endfunction

    // ---------------- clock / reset / DUT signals ----------------
    logic   clk      = 1'b0;
    logic   rst_n    = 1'b0;
    logic   en       = 1'b0;
    logic   flush    = 1'b0;
    logic   in_valid = 1'b0;
    lanes_t in_data  = '0;

    logic   ov [NDUT];
    logic   fl [NDUT];
    lanes_t od [NDUT];
`ifdef NTT_DELAY_PROG_EN
    logic [DW-1:0] cfg [NDUT];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        ntt_delay_line #(
            .WIDTH     (WIDTH),
            .LANES     (LANES),
            .MAX_DELAY (MAX_DELAY),
            .DELAY     (dly_of(g))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .flush     (flush),
`ifdef NTT_DELAY_PROG_EN
            .delay_cfg (cfg[g]),
`endif
            .in_valid  (in_valid),
            .in_data   (in_data),
            .out_valid (ov[g]),
            .out_data  (od[g]),
            .filled    (fl[g])
        );
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    bit mdl3_on  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every sample accepted since the last reset/flush, oldest first.
    logic [W-1:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (flush) begin
            exp_q.delete();
        end else if (en) begin
            exp_q.push_back({in_valid, in_data});
        end
    end

    task automatic check_model(input int g);
        int           d;
        int           n;
        logic [W-1:0] e;
        d = dly_of(g);
        n = exp_q.size();
        if (d == 0) begin
            check($sformatf("d%0d_valid", d), 32'(ov[g]), 32'(in_valid & en));
            check($sformatf("d%0d_data", d), 32'(od[g]), 32'(in_data));
            check($sformatf("d%0d_filled", d), 32'(fl[g]), 32'd1);
        end else begin
            check($sformatf("d%0d_filled", d), 32'(fl[g]), 32'(n >= d));
            if (n >= d) begin
                e = exp_q[n - d];
                check($sformatf("d%0d_valid", d), 32'(ov[g]), 32'(e[W-1]));
                if (e[W-1]) begin
                    check($sformatf("d%0d_data", d), 32'(od[g]), 32'(e[W-2:0]));
                end
            end else begin
                check($sformatf("d%0d_valid", d), 32'(ov[g]), 32'd0);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (g != IDX_D4 || mdl3_on) begin
                check_model(g);
            end
        end
    end

    // ---------------- directed table for the D=4 instance ----------------
    typedef struct {
        logic             en;
        logic             fl;
        logic             vld;
        logic [WIDTH-1:0] din;
        logic             ev;
        logic [WIDTH-1:0] edat;
        logic             ef;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic f, input logic v, input int din,
                                input logic ev, input int edat, input logic ef);
        vec_t r;
        r.en = e; r.fl = f; r.vld = v; r.din = WIDTH'(din);
        r.ev = ev; r.edat = WIDTH'(edat); r.ef = ef;
        return r;
    endfunction

    // Lane 1 carries a fixed transform of lane 0 so lane crosstalk shows up.
    localparam logic [WIDTH-1:0] L1X = 12'hA5A;

    task automatic drive(input logic e, input logic f, input logic v, input lanes_t d);
        en       = e;
        flush    = f;
        in_valid = v;
        in_data  = d;
    endtask

    vec_t tbl[$];

    initial begin
        logic [WIDTH-1:0] x;
        // en fl vld din  -> out_valid out_lane0 filled
        tbl.push_back(mk(1, 0, 1,  1, 0,  0, 0));
        tbl.push_back(mk(1, 0, 1,  2, 0,  0, 0));
        tbl.push_back(mk(1, 0, 1,  3, 0,  0, 0));
        tbl.push_back(mk(1, 0, 1,  4, 1,  1, 1));
        tbl.push_back(mk(1, 0, 1,  5, 1,  2, 1));
        tbl.push_back(mk(1, 0, 1,  6, 1,  3, 1));
        tbl.push_back(mk(0, 0, 1, 99, 1,  3, 1));   // stall: everything holds
        tbl.push_back(mk(0, 0, 1, 98, 1,  3, 1));
        tbl.push_back(mk(0, 0, 1, 97, 1,  3, 1));
        tbl.push_back(mk(1, 0, 1,  7, 1,  4, 1));   // resumes with no gap
        tbl.push_back(mk(1, 0, 1,  8, 1,  5, 1));
        tbl.push_back(mk(1, 0, 1,  9, 1,  6, 1));
        tbl.push_back(mk(1, 0, 0, 10, 1,  7, 1));
        tbl.push_back(mk(1, 0, 1, 11, 1,  8, 1));
        tbl.push_back(mk(1, 0, 1, 12, 1,  9, 1));
        tbl.push_back(mk(1, 0, 1, 13, 0,  0, 1));   // invalid sample 10 emerges
        tbl.push_back(mk(1, 0, 1, 14, 1, 11, 1));
        tbl.push_back(mk(1, 1, 1, 15, 0,  0, 0));   // flush, 15 dropped
        tbl.push_back(mk(1, 0, 1, 16, 0,  0, 0));
        tbl.push_back(mk(1, 0, 1, 17, 0,  0, 0));
        tbl.push_back(mk(1, 0, 1, 18, 0,  0, 0));
        tbl.push_back(mk(1, 0, 1, 19, 1, 16, 1));
        tbl.push_back(mk(0, 1, 1, 60, 0,  0, 0));   // flush overrides stall
        tbl.push_back(mk(0, 0, 1, 50, 0,  0, 0));
        tbl.push_back(mk(1, 0, 1, 20, 0,  0, 0));   // stale RAM stays hidden
        tbl.push_back(mk(1, 0, 1, 21, 0,  0, 0));
        tbl.push_back(mk(1, 0, 1, 22, 0,  0, 0));
        tbl.push_back(mk(1, 0, 1, 23, 1, 20, 1));

`ifdef NTT_DELAY_PROG_EN
        for (int g = 0; g < NDUT; g++) cfg[g] = DW'(dly_of(g));
`endif

        // ---- reset state ----
        #12;
        check("rst_valid", 32'(ov[IDX_D4]), 32'd0);
        check("rst_data", 32'(od[IDX_D4]), 32'd0);
        check("rst_filled", 32'(fl[IDX_D4]), 32'd0);
        check("rst_d0_filled", 32'(fl[0]), 32'd1);
        #1 rst_n = 1'b1;

        // ---- table ----
        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].fl, tbl[i].vld, mk_lanes(tbl[i].din, tbl[i].din ^ L1X));
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_valid", i), 32'(ov[IDX_D4]), 32'(tbl[i].ev));
            check($sformatf("tbl%0d_filled", i), 32'(fl[IDX_D4]), 32'(tbl[i].ef));
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_data", i), 32'(od[IDX_D4]),
                      32'(mk_lanes(tbl[i].edat, tbl[i].edat ^ L1X)));
            end
        end

        // ---- D=5: flush after 20 cycles, pre-flush samples never return ----
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 1'b0, 1'b1, mk_lanes(WIDTH'(500 + c), WIDTH'(1500 + c)));
            @(posedge clk);
            #1;
        end
        drive(1'b1, 1'b1, 1'b1, mk_lanes(12'd777, 12'd777));
        @(posedge clk);
        #1;
        check("d5_flush_valid", 32'(ov[IDX_D5]), 32'd0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, 1'b1, mk_lanes(WIDTH'(600 + k), WIDTH'(1600 + k)));
            @(posedge clk);
            #1;
            if (k < 4) begin
                check($sformatf("d5_post_flush%0d_valid", k), 32'(ov[IDX_D5]), 32'd0);
            end else begin
                check($sformatf("d5_post_flush%0d_valid", k), 32'(ov[IDX_D5]), 32'd1);
                check($sformatf("d5_post_flush%0d_data", k), 32'(od[IDX_D5]),
                      32'(mk_lanes(WIDTH'(596 + k), WIDTH'(1596 + k))));
            end
        end

        // ---- random traffic, all instances against the sample history ----
        for (int c = 0; c < 1000; c++) begin
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 63) == 0),
                  1'($urandom_range(0, 1)),
                  mk_lanes(WIDTH'($urandom_range(0, 4095)), WIDTH'($urandom_range(0, 4095))));
            @(posedge clk);
            #1;
        end

        // ---- asynchronous reset in mid-run ----
        drive(1'b1, 1'b0, 1'b1, mk_lanes(12'd42, 12'd43));
        #2 rst_n = 1'b0;
        #1;
        for (int g = 1; g < NDUT; g++) begin
            check($sformatf("arst_d%0d_valid", dly_of(g)), 32'(ov[g]), 32'd0);
            check($sformatf("arst_d%0d_data", dly_of(g)), 32'(od[g]), 32'd0);
            check($sformatf("arst_d%0d_filled", dly_of(g)), 32'(fl[g]), 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 1'b0, 1'b1, mk_lanes(WIDTH'(k), WIDTH'(k)));
            @(posedge clk);
            #1;
            check($sformatf("after_rst%0d_d4_valid", k), 32'(ov[IDX_D4]), 32'(k >= 4));
        end
        check("after_rst_d4_data", 32'(od[IDX_D4]), 32'(mk_lanes(12'd2, 12'd2)));

`ifdef NTT_DELAY_PROG_EN
        // ---- runtime reconfiguration of the D=4 instance ----
        mdl3_on = 1'b0;
        cfg[IDX_D4] = DW'(7);
        drive(1'b1, 1'b0, 1'b1, mk_lanes(12'd200, 12'd200));
        @(posedge clk);
        #1;
        check("cfg7_flush_valid", 32'(ov[IDX_D4]), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b0, 1'b1, mk_lanes(WIDTH'(200 + k), WIDTH'(200 + k)));
            @(posedge clk);
            #1;
            check($sformatf("cfg7_%0d_valid", k), 32'(ov[IDX_D4]), 32'(k >= 7));
            if (k >= 7) begin
                x = WIDTH'(194 + k);
                check($sformatf("cfg7_%0d_data", k), 32'(od[IDX_D4]), 32'(mk_lanes(x, x)));
            end
        end
        cfg[IDX_D4] = DW'(99);
        drive(1'b1, 1'b0, 1'b1, mk_lanes(12'd300, 12'd300));
        @(posedge clk);
        #1;
        for (int k = 1; k <= 64; k++) begin
            drive(1'b1, 1'b0, 1'b1, mk_lanes(WIDTH'(300 + k), WIDTH'(300 + k)));
            @(posedge clk);
            #1;
            if (k == 1 || k >= 63) begin
                check($sformatf("cfg99_%0d_valid", k), 32'(ov[IDX_D4]), 32'(k == 64));
            end
        end
        check("cfg99_data", 32'(od[IDX_D4]), 32'(mk_lanes(12'd301, 12'd301)));
        check("cfg99_filled", 32'(fl[IDX_D4]), 32'd1);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
